enabler_div: RTL and testbench

//  - Parametrised successor of the single-gate clock enabler: NCH independent channels, each

---
 rtl/enabler_div_pkg.sv | 15 +
 rtl/enabler_div_ch.sv | 102 ++++++++++
 rtl/enabler_div.sv | 47 ++++
 tb/tb_enabler_div.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enabler_div_pkg.sv
// Shared definitions for the enabler_div channel array.
//   - default channel count and divide-ratio width
//   - per-channel FSM state encoding
//   - optional gated-clock output selected by macro ENABLER_GCLK_EN
package enabler_div_pkg;

    localparam int unsigned NCH_DEF  = 4;
    localparam int unsigned DIVW_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

endpackage : enabler_div_pkg

// File: rtl/enabler_div_ch.sv
// One enabler channel: turns a run-enable level and a divide ratio into a
// registered one-cycle strobe every (div_i+1) cycles.
// Ports:
//   clk_i     system clock
//   reset_L   asynchronous active-low reset
//   enb_i     run enable (level)
//   div_i     divide ratio, sampled only at reload
//   estb_o    registered one-cycle enable strobe
//   active_o  channel is in RUN
//   gclk_o    gated clock (only when ENABLER_GCLK_EN is defined)
module enabler_div_ch
    import enabler_div_pkg::*;
#(
    parameter int unsigned DIVW = DIVW_DEF
) (
    input  logic            clk_i,
    input  logic            reset_L,
    input  logic            enb_i,
    input  logic [DIVW-1:0] div_i,
    output logic            estb_o,
    output logic            active_o
`ifdef ENABLER_GCLK_EN
    ,
    output logic            gclk_o
`endif
);

    ch_state_e       state_q, state_d;
    logic [DIVW-1:0] cnt_q, cnt_d;
    logic            estb_q, estb_d;

    // State, counter and strobe registers
    always_ff @(posedge clk_i or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            estb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            estb_q  <= estb_d;
        end
    end

    // Next-state: the enable level alone decides between IDLE and RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enb_i)  state_d = ST_RUN;
            ST_RUN:  if (!enb_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter and strobe: strobe on entry and whenever the count expires
    always_comb begin
        estb_d = 1'b0;
        cnt_d  = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enb_i) begin
                    estb_d = 1'b1;
                    cnt_d  = div_i;
                end
            end
            ST_RUN: begin
                if (!enb_i) begin
                    cnt_d = '0;
                end else if (cnt_q == '0) begin
                    estb_d = 1'b1;
                    cnt_d  = div_i;
                end else begin
                    cnt_d = cnt_q - DIVW'(1);
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign estb_o   = estb_q;
    assign active_o = (state_q == ST_RUN);

`ifdef ENABLER_GCLK_EN
    // Latch is transparent while clk is low, so it holds the strobe of the
    // coming high phase steady for the whole phase (no glitch on gclk).
    logic en_lat;

    always_latch begin
        if (!reset_L) begin
            en_lat <= 1'b0;
        end else if (!clk_i) begin
            en_lat <= estb_d;
        end
    end

    assign gclk_o = clk_i & en_lat;
`endif

endmodule : enabler_div_ch

// File: rtl/enabler_div.sv
// NCH independent enable-strobe generators with per-channel divide ratios.
// Optional gated-clock outputs are built when ENABLER_GCLK_EN is defined.
// Ports:
//   clk      system clock
//   reset_L  asynchronous active-low reset
//   enb      per-channel run enable
//   div      per-channel ratio, channel i at div[i*DIVW +: DIVW]
//   estb     per-channel registered one-cycle strobe, period div_i+1
//   active   per-channel RUN indicator
//   gclk     per-channel gated clock (ENABLER_GCLK_EN only)
module enabler_div
    import enabler_div_pkg::*;
#(
    parameter int unsigned NCH  = NCH_DEF,
    parameter int unsigned DIVW = DIVW_DEF
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic [NCH-1:0]      enb,
    input  logic [NCH*DIVW-1:0] div,
    output logic [NCH-1:0]      estb,
    output logic [NCH-1:0]      active
`ifdef ENABLER_GCLK_EN
    ,
    output logic [NCH-1:0]      gclk
`endif
);

    // One fully independent channel per enable bit
    for (genvar i = 0; i < int'(NCH); i++) begin : g_ch
        enabler_div_ch #(
            .DIVW(DIVW)
        ) u_ch (
            .clk_i   (clk),
            .reset_L (reset_L),
            .enb_i   (enb[i]),
            .div_i   (div[i*DIVW +: DIVW]),
            .estb_o  (estb[i]),
            .active_o(active[i])
`ifdef ENABLER_GCLK_EN
            ,
            .gclk_o  (gclk[i])
`endif
        );
    end

endmodule : enabler_div

// File: tb/tb_enabler_div.sv
module tb_enabler_div;

    localparam int NCH  = 4;
    localparam int DIVW = 8;

    logic                clk;
    logic                reset_L;
    logic [NCH-1:0]      enb;
    logic [NCH*DIVW-1:0] div;
    logic [NCH-1:0]      estb;
    logic [NCH-1:0]      active;
`ifdef ENABLER_GCLK_EN
    logic [NCH-1:0]      gclk;
`endif

    int n_cmp;
    int n_err;

    // Reference model: cycles since last strobe and the period latched then
    bit m_run  [NCH];
    bit m_estb [NCH];
    int m_k    [NCH];
    int m_p    [NCH];

    enabler_div #(.NCH(NCH), .DIVW(DIVW)) dut (
        .clk    (clk),
        .reset_L(reset_L),
        .enb    (enb),
        .div    (div),
        .estb   (estb),
        .active (active)
`ifdef ENABLER_GCLK_EN
        ,
        .gclk   (gclk)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_run[c]  = 1'b0;
            m_estb[c] = 1'b0;
            m_k[c]    = 0;
            m_p[c]    = 1;
        end
    endfunction

    // One rising edge: a strobe every (ratio+1) edges, ratio taken at each strobe
    function automatic void model_edge();
        for (int c = 0; c < NCH; c++) begin
            int d;
            d = int'(div[c*DIVW +: DIVW]);
            if (!enb[c]) begin
                m_run[c]  = 1'b0;
                m_estb[c] = 1'b0;
            end else if (!m_run[c]) begin
                m_run[c]  = 1'b1;
                m_k[c]    = 0;
                m_p[c]    = d + 1;
                m_estb[c] = 1'b1;
            end else begin
                m_k[c] = m_k[c] + 1;
                if (m_k[c] == m_p[c]) begin
                    m_k[c]    = 0;
                    m_p[c]    = d + 1;
                    m_estb[c] = 1'b1;
                end else begin
                    m_estb[c] = 1'b0;
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_div(input int c, input int d);
        div[c*DIVW +: DIVW] = DIVW'(d);
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        enb     = '1;
        for (int c = 0; c < NCH; c++) set_div(c, 3);
        model_reset();
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (estb !== '0 || active !== '0) begin
                n_err++;
                $display("FAIL reset_hold t=%0t estb=%b active=%b required 0/0", $time, estb, active);
            end
`ifdef ENABLER_GCLK_EN
            n_cmp++;
            if (gclk !== '0) begin
                n_err++;
                $display("FAIL reset_gclk t=%0t gclk=%b required 0", $time, gclk);
            end
`endif
        end
        reset_L = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            for (int c = 0; c < NCH; c++) begin
                n_cmp++;
                if (estb[c] !== m_estb[c] || active[c] !== m_run[c]) begin
                    n_err++;
                    $display("FAIL reset_release ch%0d t=%0t estb=%b active=%b required %b/%b",
                             c, $time, estb[c], active[c], m_estb[c], m_run[c]);
                end
            end
        end
    endtask

    task automatic test_ratios();
        int exp_p [NCH];
        int last  [NCH];
        exp_p = '{1, 2, 4, 256};
        enb = '0;
        tick();
        set_div(0, 0); set_div(1, 1); set_div(2, 3); set_div(3, 255);
        enb = '1;
        for (int c = 0; c < NCH; c++) last[c] = -1;
        for (int n = 0; n < 600; n++) begin
            tick();
            if (n == 0) begin
                n_cmp++;
                if (estb !== 4'hF) begin
                    n_err++;
                    $display("FAIL ratios_first_edge estb=%b required 1111", estb);
                end
            end
            for (int c = 0; c < NCH; c++) begin
                n_cmp++;
                if (estb[c] !== m_estb[c] || active[c] !== m_run[c]) begin
                    n_err++;
                    $display("FAIL ratios ch%0d cyc=%0d estb=%b active=%b required %b/%b",
                             c, n, estb[c], active[c], m_estb[c], m_run[c]);
                end
                if (estb[c] === 1'b1) begin
                    if (last[c] >= 0) begin
                        n_cmp++;
                        if (n - last[c] != exp_p[c]) begin
                            n_err++;
                            $display("FAIL ratios_period ch%0d got %0d required %0d", c, n - last[c], exp_p[c]);
                        end
                    end
                    last[c] = n;
                end
            end
        end
    endtask

    task automatic test_midchange();
        enb = '0;
        tick();
        set_div(0, 3);
        enb = 4'b0001;
        tick();
        tick();
        set_div(0, 1);
        for (int n = 0; n < 12; n++) begin
            tick();
            n_cmp++;
            if (estb[0] !== m_estb[0] || active[0] !== m_run[0]) begin
                n_err++;
                $display("FAIL midchange cyc=%0d estb=%b active=%b required %b/%b",
                         n, estb[0], active[0], m_estb[0], m_run[0]);
            end
        end
    endtask

    task automatic test_enb_glitch();
        for (int c = 0; c < NCH; c++) set_div(c, 4);
        enb = '1;
        for (int n = 0; n < 14; n++) begin
            if (n == 6) enb[1] = 1'b0;
            if (n == 7) enb[1] = 1'b1;
            tick();
            for (int c = 0; c < NCH; c++) begin
                n_cmp++;
                if (estb[c] !== m_estb[c] || active[c] !== m_run[c]) begin
                    n_err++;
                    $display("FAIL enb_glitch ch%0d cyc=%0d estb=%b active=%b required %b/%b",
                             c, n, estb[c], active[c], m_estb[c], m_run[c]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        enb = '1;
        for (int c = 0; c < NCH; c++) set_div(c, 2);
        for (int n = 0; n < 5; n++) tick();
        #2;
        reset_L = 1'b0;
        #1;
        n_cmp++;
        if (estb !== '0 || active !== '0) begin
            n_err++;
            $display("FAIL async_reset estb=%b active=%b required 0/0", estb, active);
        end
        model_reset();
        #2;
        reset_L = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            for (int c = 0; c < NCH; c++) begin
                n_cmp++;
                if (estb[c] !== m_estb[c] || active[c] !== m_run[c]) begin
                    n_err++;
                    $display("FAIL async_resume ch%0d cyc=%0d estb=%b active=%b required %b/%b",
                             c, n, estb[c], active[c], m_estb[c], m_run[c]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) enb[$urandom_range(0, NCH-1)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) set_div(int'($urandom_range(0, NCH-1)), int'($urandom_range(0, 6)));
            tick();
            for (int c = 0; c < NCH; c++) begin
                n_cmp++;
                if (estb[c] !== m_estb[c] || active[c] !== m_run[c]) begin
                    n_err++;
                    $display("FAIL random ch%0d cyc=%0d estb=%b active=%b required %b/%b",
                             c, n, estb[c], active[c], m_estb[c], m_run[c]);
                end
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_L = 1'b0;
        enb     = '0;
        div     = '0;
        test_reset();
        test_ratios();
        test_midchange();
        test_enb_glitch();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_enabler_div
